// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I core.
// States, opcodes, datapath select codes and ALU operation classes.
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the ALU operation class and funct fields
// onto the ALU control code.
import core_pkg::*;

module aludec (
    input  aluop_t     aluop,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNC: begin
                unique case (funct3)
                    // I-type never subtracts: funct7b5 there is imm bits
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the
// shared memory/ALU datapath through fetch, decode, execute, writeback.
import core_pkg::*;

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcupdate, branch;
    logic   irw, memw, regw, ill;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d   = S_FETCH;
        aluop     = ALUOP_ADD;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        irw       = 1'b0;
        memw      = 1'b0;
        regw      = 1'b0;
        ill       = 1'b0;
        adrsrc    = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        unique case (state_q)
            S_FETCH: begin
                state_d   = S_DECODE;
                irw       = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURES;
                pcupdate  = 1'b1;
            end
            S_DECODE: begin
                // ALUOut holds OldPC + imm for a taken branch or jal
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                unique case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d = S_FETCH;
                        ill     = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regw      = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNC;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNC;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regw = 1'b1;
            end
            S_JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
    assign irwrite  = irw & ~reset;
    assign memwrite = memw & ~reset;
    assign regwrite = regw & ~reset;
    assign illegal  = ill & ~reset;

    always_comb begin
        immsrc = IMM_I;
        unique case (op)
            OP_LW, OP_I: immsrc = IMM_I;
            OP_SW:       immsrc = IMM_S;
            OP_BEQ:      immsrc = IMM_B;
            OP_JAL:      immsrc = IMM_J;
            default:     immsrc = IMM_I;
        endcase
    end

    aludec u_aludec (
        .aluop      (aluop),
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle vector bench for the multicycle controller FSM.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .regwrite   (regwrite),
        .illegal    (illegal),
        .state      (state)
    );

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [3:0] st;
        logic [2:0] alc;
        logic       pcw;
        logic [1:0] imm;
        logic       ill;
    } vec_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    vec_t tv[$];
    vec_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    // {adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, regwrite}
    function automatic logic [9:0] moore(input logic [3:0] s);
        case (s)
            4'd0:    return {1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0};
            4'd1:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0};
            4'd2:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
            4'd3:    return {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            4'd4:    return {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1};
            4'd5:    return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            4'd6:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
            4'd7:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
            4'd8:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
            4'd9:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0};
            4'd10:   return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
            default: return 10'd0;
        endcase
    endfunction

    task automatic add(input logic rst, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7,
                       input logic z, input logic [3:0] st,
                       input logic [2:0] alc, input logic pcw,
                       input logic [1:0] imm, input logic ill);
        vec_t v;
        v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
        v.st = st; v.alc = alc; v.pcw = pcw; v.imm = imm; v.ill = ill;
        tv.push_back(v);
    endtask

    task automatic check(input vec_t e, input int idx);
        logic [9:0] m, got;
        logic       bad;
        m = moore(e.st);
        if (e.rst) begin
            m[7] = 1'b0;
            m[8] = 1'b0;
            m[0] = 1'b0;
        end
        got = {adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, regwrite};
        bad = 1'b0;
        if (state !== e.st) begin
            $display("FAIL v%0d state got %0d want %0d", idx, state, e.st);
            bad = 1'b1;
        end
        if (got !== m) begin
            $display("FAIL v%0d moore got %b want %b", idx, got, m);
            bad = 1'b1;
        end
        if (alucontrol !== e.alc) begin
            $display("FAIL v%0d alucontrol got %b want %b", idx, alucontrol, e.alc);
            bad = 1'b1;
        end
        if (pcwrite !== e.pcw) begin
            $display("FAIL v%0d pcwrite got %b want %b", idx, pcwrite, e.pcw);
            bad = 1'b1;
        end
        if (immsrc !== e.imm) begin
            $display("FAIL v%0d immsrc got %b want %b", idx, immsrc, e.imm);
            bad = 1'b1;
        end
        if (illegal !== e.ill) begin
            $display("FAIL v%0d illegal got %b want %b", idx, illegal, e.ill);
            bad = 1'b1;
        end
        nvec++;
        if (bad) nerr++;
    endtask

    initial begin
        vec_t e;
        int   n;
        // reset held three cycles, lw presented
        repeat (3) add(1, LW, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0);
        // lw: 0 1 2 3 4
        add(0, LW, 0, 0, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, LW, 0, 0, 0, 1, 3'b000, 0, 2'b00, 0);
        add(0, LW, 0, 0, 0, 2, 3'b000, 0, 2'b00, 0);
        add(0, LW, 0, 0, 0, 3, 3'b000, 0, 2'b00, 0);
        add(0, LW, 0, 0, 0, 4, 3'b000, 0, 2'b00, 0);
        // sw: 0 1 2 5
        add(0, SW, 0, 0, 0, 0, 3'b000, 1, 2'b01, 0);
        add(0, SW, 0, 0, 0, 1, 3'b000, 0, 2'b01, 0);
        add(0, SW, 0, 0, 0, 2, 3'b000, 0, 2'b01, 0);
        add(0, SW, 0, 0, 0, 5, 3'b000, 0, 2'b01, 0);
        // R sub
        add(0, RT, 3'b000, 1, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, RT, 3'b000, 1, 0, 1, 3'b000, 0, 2'b00, 0);
        add(0, RT, 3'b000, 1, 0, 6, 3'b001, 0, 2'b00, 0);
        add(0, RT, 3'b000, 1, 0, 7, 3'b000, 0, 2'b00, 0);
        // addi with bit30 set still adds
        add(0, IT, 3'b000, 1, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, IT, 3'b000, 1, 0, 1, 3'b000, 0, 2'b00, 0);
        add(0, IT, 3'b000, 1, 0, 8, 3'b000, 0, 2'b00, 0);
        add(0, IT, 3'b000, 1, 0, 7, 3'b000, 0, 2'b00, 0);
        // R slt
        add(0, RT, 3'b010, 0, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, RT, 3'b010, 0, 0, 1, 3'b000, 0, 2'b00, 0);
        add(0, RT, 3'b010, 0, 0, 6, 3'b101, 0, 2'b00, 0);
        add(0, RT, 3'b010, 0, 0, 7, 3'b000, 0, 2'b00, 0);
        // andi
        add(0, IT, 3'b111, 0, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, IT, 3'b111, 0, 0, 1, 3'b000, 0, 2'b00, 0);
        add(0, IT, 3'b111, 0, 0, 8, 3'b010, 0, 2'b00, 0);
        add(0, IT, 3'b111, 0, 0, 7, 3'b000, 0, 2'b00, 0);
        // R or
        add(0, RT, 3'b110, 0, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, RT, 3'b110, 0, 0, 1, 3'b000, 0, 2'b00, 0);
        add(0, RT, 3'b110, 0, 0, 6, 3'b011, 0, 2'b00, 0);
        add(0, RT, 3'b110, 0, 0, 7, 3'b000, 0, 2'b00, 0);
        // beq taken
        add(0, BEQ, 0, 0, 1, 0, 3'b000, 1, 2'b10, 0);
        add(0, BEQ, 0, 0, 1, 1, 3'b000, 0, 2'b10, 0);
        add(0, BEQ, 0, 0, 1, 10, 3'b001, 1, 2'b10, 0);
        // beq not taken
        add(0, BEQ, 0, 0, 0, 0, 3'b000, 1, 2'b10, 0);
        add(0, BEQ, 0, 0, 0, 1, 3'b000, 0, 2'b10, 0);
        add(0, BEQ, 0, 0, 0, 10, 3'b001, 0, 2'b10, 0);
        // jal: 0 1 9 7
        add(0, JAL, 0, 0, 0, 0, 3'b000, 1, 2'b11, 0);
        add(0, JAL, 0, 0, 0, 1, 3'b000, 0, 2'b11, 0);
        add(0, JAL, 0, 0, 0, 9, 3'b000, 1, 2'b11, 0);
        add(0, JAL, 0, 0, 0, 7, 3'b000, 0, 2'b11, 0);
        // unsupported opcode
        add(0, BAD, 0, 0, 0, 0, 3'b000, 1, 2'b00, 0);
        add(0, BAD, 0, 0, 0, 1, 3'b000, 0, 2'b00, 1);
        // reset landing in MEMWRITE
        add(0, SW, 0, 0, 0, 0, 3'b000, 1, 2'b01, 0);
        add(0, SW, 0, 0, 0, 1, 3'b000, 0, 2'b01, 0);
        add(0, SW, 0, 0, 0, 2, 3'b000, 0, 2'b01, 0);
        add(1, SW, 0, 0, 0, 5, 3'b000, 0, 2'b01, 0);
        add(0, SW, 0, 0, 0, 0, 3'b000, 1, 2'b01, 0);

        foreach (tv[i]) begin
            @(posedge clk);
            #1;
            reset    = tv[i].rst;
            op       = tv[i].op;
            funct3   = tv[i].f3;
            funct7b5 = tv[i].f7;
            zero     = tv[i].z;
            sb.push_back(tv[i]);
            @(negedge clk);
            e = sb.pop_front();
            check(e, i);
        end

        // lw again: wait, bounded, for the register writeback state
        @(posedge clk);
        #1;
        reset = 1'b0;
        op    = LW;
        n = 0;
        @(negedge clk);
        while (state !== 4'd4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (state !== 4'd4) begin
            $display("FAIL lw_wb timeout state got %0d want 4", state);
            nerr++;
        end else if (regwrite !== 1'b1 || memwrite !== 1'b0 || resultsrc !== 2'b01) begin
            $display("FAIL lw_wb rw/mw/rs got %b%b%b want 1001",
                     regwrite, memwrite, resultsrc);
            nerr++;
        end
        @(negedge clk);
        nvec++;
        if (state !== 4'd0) begin
            $display("FAIL lw_ret state got %0d want 0", state);
            nerr++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the multicycle RV32I core.
- Sequences a shared datapath (one memory, one ALU, the immediate extender) through Fetch/Decode/Execute/Writeback states.
- Drives every datapath select and write-enable, including immsrc for the extender (00 I, 01 S, 10 B, 11 J).
- Sits between the instruction register fields and the datapath muxes.

Parameters:
- none (opcode set fixed: lw, sw, R-type, I-type ALU, beq, jal)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address select: 0 PC, 1 ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register / OldPC enable
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alusrca  out  2  00 PC, 01 OldPC, 10 rs1 data
- alusrcb  out  2  00 rs2 data, 01 immext, 10 constant 4
- immsrc  out  2  extender format select
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- regwrite  out  1  register file write enable
- illegal  out  1  one-cycle pulse: unsupported opcode seen in DECODE
- state  out  4  current state encoding, for verification

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). The state register is the only storage.
- Reset: state <= FETCH (0). While reset = 1, pcwrite, irwrite, memwrite, regwrite and illegal are forced 0; all other outputs decode normally.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11-15 are unreachable and go to FETCH with all enables 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R (0110011) -> EXECUTER; I (0010011) -> EXECUTEI; jal (1101111) -> JAL; beq (1100011) -> BEQ; any other op -> FETCH with illegal = 1 for that cycle.
  - MEMADR: lw (0000011) -> MEMREAD, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI / JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
- Moore outputs per state (unlisted enables 0, unlisted selects 00):
  - FETCH: adrsrc 0, irwrite 1, alusrca 00, alusrcb 10, aluop add, resultsrc 10, pcupdate 1.
  - DECODE: alusrca 01, alusrcb 01, aluop add (computes branch/jump target).
  - MEMADR: alusrca 10, alusrcb 01, aluop add.
  - MEMREAD: adrsrc 1, resultsrc 00.
  - MEMWB: resultsrc 01, regwrite 1.
  - MEMWRITE: adrsrc 1, resultsrc 00, memwrite 1.
  - EXECUTER: alusrca 10, alusrcb 00, aluop func.
  - EXECUTEI: alusrca 10, alusrcb 01, aluop func.
  - ALUWB: resultsrc 00, regwrite 1.
  - JAL: alusrca 01, alusrcb 10, aluop add, resultsrc 00, pcupdate 1.
  - BEQ: alusrca 10, alusrcb 00, aluop sub, resultsrc 00, branch 1.
- pcwrite = pcupdate | (branch & zero). Combinational on zero, same cycle.
- immsrc: combinational from op, state-independent.
  - 0000011 / 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- alucontrol:
  - aluop add -> 000; aluop sub -> 001.
  - aluop func, by funct3: 000 -> sub if (op[5] & funct7b5) else add; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
- No output is ever X; all defaults are defined.
- Latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3.
- op, funct3 and funct7b5 must be stable from DECODE to the return to FETCH (guaranteed by irwrite timing).
- Reset asserted mid-instruction: the next state is FETCH, and no memory or register write occurs in the reset cycle.

Decomposition:
- Shared package core_pkg:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - immsrc, alucontrol, resultsrc and alusrc encodings
  - aluop enum (add/sub/func)
- Sub-modules:
  - aludec: combinational; inputs aluop, op[5], funct3, funct7b5; output alucontrol.
  - instrdec: the immsrc decode, inlined or a small separate module.

Test Plan:
- Reset held 3 cycles, then released with op=0000011 -> all write enables 0 during reset. Sequence: state 0,1,2,3,4,0; irwrite=1 only in state 0; regwrite=1 only in state 4; adrsrc=1 in state 3.
- sw (op=0100011) -> states 0,1,2,5,0; memwrite=1 only in state 5; immsrc=01 throughout.
- R sub (op=0110011, funct3=000, funct7b5=1) -> alucontrol=001 in state 6. Same input with op=0010011 (addi) gives 000 in state 8. funct3=010 -> 101; funct3=111 -> 010.
- beq with zero=1 in state 10 -> pcwrite=1, alucontrol=001, immsrc=10. Repeat with zero=0 -> pcwrite=0; next state is 0 either way.
- jal (op=1101111) -> states 0,1,9,7,0; pcwrite=1 in states 0 and 9; immsrc=11; regwrite=1 in state 7.
- op=0000000 in DECODE -> illegal=1 for one cycle, next state 0, no writes. Separately, reset asserted in state 5 -> memwrite=0 that cycle, state=0 next.
